inst_fetch: RTL

- Instruction fetch stage for the single-issue RV32I core.
- Holds the PC and issues one instruction-memory request at a time.
- Captures the returned word into a fetch/decode holding register and presents it to the decoder. The immediate extractor is fed from this register.
- Accepts PC redirects from execute (branches, jal, jalr) and squashes any wrong-path fetch.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: definitions shared by the fetch stage, decoder and
// immediate extractor.
//   RV_NOP_INST  : canonical nop (addi x0,x0,0) shown when nothing is valid
//   RV_RESET_PC  : default PC after reset
//   fetch_state_e: fetch FSM encodings
//   OPC_*        : RV32I major opcodes
package inst_fetch_pkg;

    localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: single-issue RV32I fetch stage. Holds the PC, issues one
// instruction-memory request at a time and parks the returned word in a
// fetch/decode holding register until the decoder takes it.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   imem_req/imem_addr       request to instruction memory (addr = PC)
//   imem_gnt                 request accepted this cycle
//   imem_rvalid/imem_rdata   returned instruction word
//   redirect_valid/_pc       PC change from execute (highest priority)
//   id_ready                 decoder accepts the held instruction
//   id_valid/id_inst/id_pc   held instruction presented to decode
//   id_fault                 (FETCH_MISALIGN_CHECK_EN only) misaligned redirect
//
// Build option FETCH_MISALIGN_CHECK_EN: a redirect to a non-word-aligned
// target does not fetch; it presents a faulting nop at the target instead.
// Without it the low two target bits are dropped.
//
// state  | meaning
// S_REQ  | request driven, waiting for imem_gnt
// S_WAIT | request granted, waiting for imem_rvalid (kill => drop the data)
// S_HOLD | instruction held on id_*, waiting for id_ready
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_PC,
    parameter logic [31:0] NOP_INST = RV_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        id_fault,
`endif
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_inst_q, id_inst_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  redirect_tgt;
    fetch_state_e hold_exit;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic id_fault_q, id_fault_d;
    assign redirect_tgt = redirect_pc;
`else
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Leaving S_HOLD with a killed request still in flight (only possible
    // after a faulting redirect) must first wait out that response.
    assign hold_exit = (kill_q && !imem_rvalid) ? S_WAIT : S_REQ;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        id_fault_d = id_fault_q;
`endif

        case (state_q)
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        id_inst_d  = imem_rdata;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (kill_q && imem_rvalid) kill_d = 1'b0;
                if (id_ready) begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                    state_d    = hold_exit;
`ifdef FETCH_MISALIGN_CHECK_EN
                    id_fault_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d    = S_REQ;
                kill_d     = 1'b0;
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
            end
        endcase

        // Redirect overrides everything above, including any PC increment.
        if (redirect_valid) begin
            pc_d       = redirect_tgt;
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            case (state_q)
                S_REQ: begin
                    // A same-cycle grant leaves the old-PC request in flight.
                    kill_d  = imem_gnt;
                    state_d = imem_gnt ? S_WAIT : S_REQ;
                end
                S_WAIT: begin
                    kill_d  = !imem_rvalid;
                    state_d = imem_rvalid ? S_REQ : S_WAIT;
                end
                S_HOLD: begin
                    kill_d  = kill_q && !imem_rvalid;
                    state_d = hold_exit;
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            id_fault_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = S_HOLD;
                id_valid_d = 1'b1;
                id_fault_d = 1'b1;
                id_pc_d    = redirect_pc;
                id_inst_d  = NOP_INST;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
            id_fault_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            id_fault_q <= id_fault_d;
`endif
        end
    end

    assign imem_req  = (state_q == S_REQ) & ~rst;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign id_fault  = id_fault_q;
`endif

endmodule
